hfrv_debug_uart_tx: RTL
=======================

Name: hfrv_debug_uart_tx

Overview:
- Memory-mapped debug byte sink sitting directly downstream of the core's data bus, in dut_top beside the memory model.
- Accepts byte stores to the debug UART address and buffers them in a small FIFO.
- Serializes each byte as 8N1 on a tx line.
- Emits a one-cycle byte strobe per completed frame, which the testbench monitor consumes to build the UART log file.

Parameters:
- DEBUG_ADDR, 32'hf00000d0, byte address decoded as the debug UART data register.
- CLK_DIV, 16, clk cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 8, byte entries; power of two, range 2..64.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- address  in  32  core data bus address
- data_w  in  32  core store data; byte taken from data_w[7:0]
- data_we  in  4  core byte write enables; any nonzero bit = store
- stall  out  1  backpressure to core; high while FIFO full
- tx  out  1  serial line, idle high
- busy  out  1  high while a frame is in flight or FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- byte_valid  out  1  one-cycle pulse at end of each frame's stop bit
- byte_data  out  8  byte just transmitted; valid only with byte_valid

Behaviour:
- Reset values: tx=1, stall=0, busy=0, fifo_count=0, byte_valid=0, byte_data=0, FSM=IDLE, bit and baud counters=0. Reset asserted mid-frame forces tx high asynchronously and drops the frame and FIFO contents.
- Push condition: address==DEBUG_ADDR && data_we!=0 && !full, sampled at a rising edge. Stores to any other address are ignored.
- stall = full. It is combinational from the registered count, so there is no same-cycle pop bypass. A store held while stalled is accepted on the first edge where full is low. The core keeps address, data and data_we stable while stalled.
- FIFO: circular buffer with read/write pointers one bit wider than the index. Full and empty are derived from the pointer MSB. Push and pop in the same cycle leave the count unchanged, and this is legal when neither full nor empty.
- FSM states:
  - IDLE: tx=1. If FIFO non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for CLK_DIV cycles, then DATA.
  - DATA: tx=shift[0], LSB first, CLK_DIV cycles per bit. The bit counter runs 0..7; go to STOP after bit 7.
  - STOP: tx=1 for CLK_DIV cycles. In the last STOP cycle, pulse byte_valid with byte_data = frame byte. Then, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Latency: store accepted at edge N with FIFO previously empty and FSM in IDLE → pop at edge N+1 → tx falls after edge N+1. Frame length is exactly 10*CLK_DIV cycles. byte_valid is high during the cycle ending at edge N+1+10*CLK_DIV.
- Baud counter: counts 0..CLK_DIV-1 and wraps; the bit advances on wrap. Its width is 16 bits regardless of CLK_DIV.
- busy = (FSM!=IDLE) || !empty.
- Full boundary: with the FIFO at FIFO_DEPTH-1 and a push, stall rises the next cycle. On a pop while full, stall falls the next cycle.

Decomposition:
- Shared package hfrv_debug_pkg holds:
  - DEBUG_UART_ADDR constant (32'hf00000d0)
  - typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} uart_tx_state_t
  - UART_FRAME_BITS = 10
- One sub-module: hfrv_byte_fifo, a parameterised synchronous FIFO with push, pop, full, empty, count and async active-high reset. It is reusable for a future RX path.
- The serializer FSM stays in the top module.

Test Plan:
1. Single byte: CLK_DIV=4, store 0x41 to 0xf00000d0 with data_we=4'b0001.
   - tx low 4 cycles, then 1,0,0,0,0,0,1,0 (LSB first), then high 4 cycles.
   - byte_valid pulses once with 0x41, 40 cycles after pop.
2. Address filter: store 0x55 to 0xf00000d4, then a read (data_we=0) at 0xf00000d0.
   - fifo_count stays 0, tx stays 1, no byte_valid.
3. Back-to-back and full: CLK_DIV=2, FIFO_DEPTH=8, ten consecutive stores 0x30..0x39.
   - stall asserts after the FIFO fills and the held store completes when a slot frees.
   - byte_valid yields 0x30..0x39 in order, spaced exactly 20 cycles with no idle gap.
   - busy drops after the last stop bit.
4. Simultaneous push/pop: a push lands on the same edge as a STOP→START pop with fifo_count=3.
   - fifo_count stays 3 and the byte order is preserved.
5. Reset mid-frame: assert reset during DATA bit 3 of 0xA5 with 2 bytes queued.
   - tx=1 immediately; fifo_count=0, busy=0.
   - No byte_valid for 0xA5 or the queued bytes.
   - A new store of 0x5A after release transmits normally.
6. Divider edge: CLK_DIV=2, store 0xFF.
   - tx low for exactly 2 cycles, then high for 18 cycles.
   - byte_valid carries 0xFF.

Source files
------------

// File: rtl/hfrv_debug_pkg.sv
// Shared definitions for the hfrv debug byte sink (address map, serializer states, frame shape).
package hfrv_debug_pkg;

  localparam logic [31:0]  DEBUG_UART_ADDR = 32'hf00000d0;
  localparam int unsigned  UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/hfrv_byte_fifo.sv
// Synchronous circular-buffer FIFO; pointers carry one extra wrap bit so full/empty need no counter.
module hfrv_byte_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

  // Pointer advance; pushes while full and pops while empty are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rptr <= rptr + (AW+1)'(1);
      end
    end
  end

  // Storage array; left unreset since only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/hfrv_debug_uart_tx.sv
// Debug UART sink: byte stores to DEBUG_ADDR are queued and sent as 8N1 frames on tx.
module hfrv_debug_uart_tx
  import hfrv_debug_pkg::*;
#(
  parameter logic [31:0] DEBUG_ADDR = DEBUG_UART_ADDR,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   address,
  input  logic [31:0]                   data_w,
  input  logic [3:0]                    data_we,
  output logic                          stall,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          byte_valid,
  output logic [7:0]                    byte_data
);

  // Baud counter is fixed at 16 bits; the strobe is raised one count early so it lands in the last stop cycle.
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] BAUD_PRE  = 16'(CLK_DIV - 2);

  uart_tx_state_t state;
  logic [7:0]     shift;
  logic [7:0]     frame;
  logic [2:0]     bit_cnt;
  logic [15:0]    baud;
  logic           baud_wrap;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;
  logic [7:0]     head;
  logic           unused_data_hi;

  assign unused_data_hi = ^data_w[31:8];

  assign push      = (address == DEBUG_ADDR) && (data_we != 4'b0000);
  assign baud_wrap = (baud == BAUD_LAST);
  assign pop       = !empty && ((state == TX_IDLE) || ((state == TX_STOP) && baud_wrap));
  assign stall     = full;
  assign busy      = (state != TX_IDLE) || !empty;

  hfrv_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (data_w[7:0]),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Serializer: start bit, 8 data bits LSB first, stop bit; chains straight into the next frame when queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= TX_IDLE;
      tx         <= 1'b1;
      shift      <= '0;
      frame      <= '0;
      bit_cnt    <= '0;
      baud       <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else begin
      byte_valid <= 1'b0;
      case (state)
        TX_IDLE: begin
          tx   <= 1'b1;
          baud <= '0;
          if (pop) begin
            shift <= head;
            frame <= head;
            tx    <= 1'b0;
            state <= TX_START;
          end
        end
        TX_START: begin
          if (baud_wrap) begin
            baud    <= '0;
            bit_cnt <= '0;
            tx      <= shift[0];
            state   <= TX_DATA;
          end else begin
            baud <= baud + 16'd1;
          end
        end
        TX_DATA: begin
          if (baud_wrap) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        TX_STOP: begin
          if (baud == BAUD_PRE) begin
            byte_valid <= 1'b1;
            byte_data  <= frame;
          end
          if (baud_wrap) begin
            baud <= '0;
            if (pop) begin
              shift <= head;
              frame <= head;
              tx    <= 1'b0;
              state <= TX_START;
            end else begin
              tx    <= 1'b1;
              state <= TX_IDLE;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule
